// File: rtl/sequence_detector_fsm.sv
// Moore detector for the serial pattern 1-0-1-0-1 (oldest bit first), overlapping.
// Each state is named for the longest pattern prefix seen so far; S5 means a full match.
module sequence_detector_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   output logic       data_out,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b010,
      S3 = 3'b011,
      S4 = 3'b100,
      S5 = 3'b101
   } state_t;

   logic [2:0] r_state;
   logic [2:0] w_next_state;
   logic       w_detect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S0;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Leaving S5 keeps the overlapping suffix "1010" on a 0 input.
   // The unused codes 110 and 111 fall back to S0 whatever the input.
   always_comb begin
      w_next_state = S0;
      case (r_state)
         S0:      w_next_state = data_in ? S1 : S0;
         S1:      w_next_state = data_in ? S1 : S2;
         S2:      w_next_state = data_in ? S3 : S0;
         S3:      w_next_state = data_in ? S1 : S4;
         S4:      w_next_state = data_in ? S5 : S0;
         S5:      w_next_state = data_in ? S1 : S4;
         default: w_next_state = S0;
      endcase
   end

   always_comb begin
      w_detect = 1'b0;
      if (r_state == S5) begin
         w_detect = 1'b1;
      end
   end

   assign data_out = w_detect;
   assign state    = r_state;

endmodule

// File: tb/tb_sequence_detector_fsm.sv
// Randomised and directed bench for sequence_detector_fsm with a queue-based scoreboard.
// The reference model tracks bit history and the longest suffix matching a prefix of 10101.
module tb_sequence_detector_fsm;

   logic       clk;
   logic       reset;
   logic       data_in;
   logic       data_out;
   logic [2:0] state;

   sequence_detector_fsm dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .data_out (data_out),
      .state    (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: each entry is {data_out, state} expected after one rising edge
   logic [3:0] exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;

   // reference model: recent sampled bits, oldest first, at most five kept
   bit         hist[$];
   bit         pat[5];

   function automatic int match_len();
      int best;
      bit ok;
      best = 0;
      for (int k = 1; k <= 5; k++) begin
         if (hist.size() >= k) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
               if (hist[hist.size() - k + j] != pat[j]) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got {data_out,state}=%b_%b expected %b_%b at %0t",
                  name, act[3], act[2:0], exp[3], exp[2:0], $time);
      end
   endtask

   // driver: glitch data_in mid-cycle, settle the real bit, push expected response
   task automatic drive_bit(input bit b);
      int len;
      @(negedge clk);
      data_in = ~b;
      #1;
      data_in = b;
      hist.push_back(b);
      if (hist.size() > 5) void'(hist.pop_front());
      len = match_len();
      exp_q.push_back({(len == 5) ? 1'b1 : 1'b0, 3'(len)});
   endtask

   task automatic drive_seq(input bit bits[], input string name);
      for (int i = 0; i < bits.size(); i++) drive_bit(bits[i]);
   endtask

   // asynchronous reset pulse between edges; both flags must clear before the next edge
   task automatic reset_pulse();
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("async_reset", {data_out, state}, 4'b0_000);
      #1;
      reset = 1'b1;
      hist.delete();
   endtask

   task automatic illegal_state(input logic [2:0] code, input bit din);
      @(negedge clk);
      data_in = din;
      force dut.r_state = code;
      #1;
      release dut.r_state;
      #1;
      check("illegal_hold", {data_out, state}, {1'b0, code});
      @(posedge clk);
      #1;
      check("illegal_recover", {data_out, state}, 4'b0_000);
      hist.delete();
   endtask

   // monitor: after every rising edge, pop and compare if a response is due
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stream", {data_out, state}, e);
         end
      end
   end

   initial begin
      bit s_pat[]    = '{1, 0, 1, 0, 1};
      bit s_ovl[]    = '{0, 1, 1};
      bit s_clr[]    = '{0, 0};
      bit s_near[]   = '{1, 0, 0, 1, 0, 1};
      bit s_full[]   = '{0,0,1,0,1,0,1,1,0,1,0,1,1,1,0,0,0,1,0,1,0,1,1,0,0};
      bit s_part[]   = '{1, 0, 1, 0};
      int budget;
      int det_cnt;

      pat = '{1, 0, 1, 0, 1};
      data_in = 1'b0;
      reset   = 1'b0;
      #12;
      check("reset_state", {data_out, state}, 4'b0_000);
      @(negedge clk);
      reset = 1'b1;

      drive_seq(s_pat, "pattern");
      drive_seq(s_ovl, "overlap");
      drive_seq(s_clr, "clear");
      drive_seq(s_near, "near_miss");
      drive_seq(s_clr, "clear");
      drive_seq(s_clr, "clear");

      // full stream: independently confirm detection lands on bits 7, 12, 22
      det_cnt = 0;
      hist.delete();
      reset_pulse();
      for (int i = 0; i < s_full.size(); i++) begin
         drive_bit(s_full[i]);
         @(posedge clk);
         #2;
         n_checks++;
         if (data_out !== ((i + 1 == 7) || (i + 1 == 12) || (i + 1 == 22))) begin
            n_errors++;
            $display("FAIL full_stream_bit%0d: data_out=%b", i + 1, data_out);
         end
         if (data_out === 1'b1) det_cnt++;
      end
      n_checks++;
      if (det_cnt != 3) begin
         n_errors++;
         $display("FAIL full_stream_count: got %0d detections expected 3", det_cnt);
      end

      // reset mid-pattern must discard the partial 1010
      drive_seq(s_part, "partial");
      reset_pulse();
      drive_bit(1'b1);

      // randomised traffic with occasional mid-stream resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) reset_pulse();
         else if ($urandom_range(0, 2) == 0) drive_bit(1'b1);
         else drive_bit(bit'($urandom_range(0, 1)));
      end

      // drain before poking unused encodings
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d responses never observed", exp_q.size());
      end

      illegal_state(3'b110, 1'b0);
      illegal_state(3'b110, 1'b1);
      illegal_state(3'b111, 1'b0);
      illegal_state(3'b111, 1'b1);

      drive_seq(s_pat, "post_illegal");
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
